uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter among NUM_REQ byte producers using round-robin arbitration.
- Captures the winning byte and drives the transmitter's data input with a start strobe.
- Waits for frame completion, then enforces an inter-frame idle gap before the next grant.
- Sits between on-chip producers (status, debug, command echo) and the single uart_tx instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 51, clocks per UART bit; must match uart_tx.
- GAP_BITS, 1, idle bit-times inserted after each frame (0 allowed).
- TIMEOUT_BITS, 12, bit-times allowed for tx_done before the frame is abandoned.

Ports:
- arb_clk  in  1  clock.
- arb_rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  8*NUM_REQ  byte for requester i on bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- tx_data_out  out  8  byte presented to uart_tx; held stable from START until leaving WAIT.
- tx_start  out  1  one-cycle frame start strobe.
- tx_done  in  1  one-cycle end-of-stop-bit pulse from uart_tx.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; set when tx_done is missed.

Behaviour:
- Reset (synchronous, arb_rst_n=0 at a rising edge):
  - state=IDLE; round-robin pointer=0.
  - req_ready=0, tx_data_out=8'h00, tx_start=0, grant_id=0, busy=0, timeout_err=0.
  - Reset mid-frame abandons the frame immediately; no req_ready or tx_start is produced in that cycle.
- States: IDLE, START, WAIT, GAP. All outputs are registered.
- IDLE:
  - If any req_valid is high at edge T, the winner is the first valid index searching from pointer upward, modulo NUM_REQ.
  - At edge T: req_data[winner] latches into tx_data_out, grant_id=winner, req_ready[winner]=1 for exactly the cycle after T, pointer=(winner+1) mod NUM_REQ, state=START.
  - With no valid requests, state stays IDLE and the pointer is unchanged.
- START:
  - tx_start=1 for exactly this one cycle; next state WAIT; watchdog cleared to 0.
  - tx_done is ignored in START.
- WAIT:
  - Watchdog increments every cycle.
  - tx_done=1 -> GAP, with the gap counter loaded to GAP_BITS*CLKS_PER_BIT.
  - Otherwise, watchdog reaching TIMEOUT_BITS*CLKS_PER_BIT-1 -> timeout_err=1, then enter GAP.
  - tx_done arriving in the same cycle as the timeout: tx_done wins and timeout_err is not set.
- GAP:
  - Gap counter decrements to 0, then -> IDLE.
  - GAP_BITS=0: WAIT goes directly to IDLE on tx_done.
  - New requests are not granted in GAP.
- Grant rate: at most one grant per frame; no back-to-back grants without passing through START/WAIT.
- Requester rules:
  - A requester must hold valid and data stable until it sees req_ready.
  - Deasserting valid before a grant withdraws the request; no byte is sent.
  - req_valid may stay high after req_ready to request the next byte; it is re-arbitrated next time in IDLE.
- Minimum per-byte latency with GAP_BITS=0: valid to tx_start = 2 cycles (grant edge plus START cycle).
- timeout_err clears only on reset.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (IDLE, START, WAIT, GAP);
  - UART frame length constant FRAME_BITS=10;
  - default CLKS_PER_BIT=51.
- One natural sub-module: rr_arbiter_comb (combinational round-robin winner select from req_valid and pointer, outputs winner index and any_valid).
- Counters and the FSM stay in uart_tx_arbiter.

Test Plan:
- Single request: req_valid=4'b0001, data 8'hAB.
  - req_ready[0] pulses one cycle, tx_start the next cycle, tx_data_out=8'hAB, grant_id=0.
  - After tx_done, busy stays high 51 cycles, then drops.
- All four valid continuously (data 8'h10/8'h20/8'h30/8'h40).
  - Grant order is 0,1,2,3,0; each byte appears on tx_data_out in that order, one per frame.
- Pointer fairness: requester 2 granted, then req_valid=4'b0101 -> next grant is 0 (search starts at 3, wraps), not 2.
- Timeout: tx_done held 0 after tx_start.
  - timeout_err=1 exactly 612 cycles after START, then GAP, then IDLE; the next request is still serviced.
  - timeout_err stays 1.
- tx_done and the timeout threshold in the same cycle -> timeout_err stays 0.
- Reset in WAIT (arb_rst_n=0 for one edge): next cycle all outputs are 0 and state is IDLE; a pending request is re-granted starting from pointer 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StGap
    } arb_state_e;

    localparam int unsigned FRAME_BITS           = 10;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 51;

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin select: first valid index at or above ptr, wrapping modulo NUM_REQ.
module rr_arbiter_comb #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_valid
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] rotated;
    logic [IDX_W:0]     sum;

    always_comb begin
        rotated   = NUM_REQ'({req_valid, req_valid} >> ptr);
        any_valid = |req_valid;
        winner    = ptr;
        sum       = '0;
        // Scan from the far end so the closest valid offset is the final assignment.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                sum    = {1'b0, ptr} + (IDX_W + 1)'(i);
                winner = (sum >= (IDX_W + 1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W + 1)'(NUM_REQ))
                                                        : IDX_W'(sum);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NUM_REQ byte producers, with a
// tx_done watchdog and an idle gap between frames. All outputs are registered.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned GAP_BITS     = 1,
    parameter int unsigned TIMEOUT_BITS = 12
) (
    input  logic                       arb_clk,
    input  logic                       arb_rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data_out,
    output logic                       tx_start,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned IDX_W   = $clog2(NUM_REQ);
    localparam int unsigned GAP_LEN = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned TO_LEN  = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned WD_W    = $clog2(TO_LEN + 1);
    localparam int unsigned GAP_W   = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         data_q, data_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               terr_q, terr_d;

    logic [IDX_W-1:0]   winner;
    logic               any_valid;

    rr_arbiter_comb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        data_d  = data_q;
        grant_d = grant_q;
        ready_d = '0;
        start_d = 1'b0;
        terr_d  = terr_q;

        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    data_d  = req_data[{winner, 3'b000} +: 8];
                    grant_d = winner;
                    ready_d = NUM_REQ'(1) << winner;
                    ptr_d   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                start_d = 1'b1;
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                // tx_done takes priority over a watchdog expiring on the same edge.
                if (tx_done || wd_q == WD_W'(TO_LEN - 1)) begin
                    if (!tx_done) begin
                        terr_d = 1'b1;
                    end
                    if (GAP_LEN == 0) begin
                        state_d = StIdle;
                    end else begin
                        gap_d   = GAP_W'(GAP_LEN);
                        state_d = StGap;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge arb_clk) begin
        if (!arb_rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            wd_q    <= '0;
            gap_q   <= '0;
            data_q  <= 8'h00;
            grant_q <= '0;
            ready_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
        end
    end

    assign req_ready   = ready_q;
    assign tx_data_out = data_q;
    assign tx_start    = start_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed frame scenarios plus randomized requesters
// checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NR      = 4;
    localparam int CPB     = 51;
    localparam int GAPB    = 1;
    localparam int TOB     = 12;
    localparam int GAP_LEN = GAPB * CPB;
    localparam int TO_LEN  = TOB * CPB;

    logic            arb_clk   = 1'b0;
    logic            arb_rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data  = '0;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_data_out;
    logic            tx_start;
    logic            tx_done   = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Random-phase model state
    int            mptr;
    int            q[$];
    int            done_timer;
    int            done_edge;
    bit            start_exp;
    int            grants;
    int            starts;
    logic [NR-1:0] v_edge;

    always #5 arb_clk = ~arb_clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .CLKS_PER_BIT (CPB),
        .GAP_BITS     (GAPB),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .arb_clk     (arb_clk),
        .arb_rst_n   (arb_rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data_out (tx_data_out),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge arb_clk);
        #1;
        cyc++;
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [7:0] d);
        req_data[8*i +: 8] = d;
        req_valid[i]       = 1'b1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        tx_done   = 1'b0;
        arb_rst_n = 1'b0;
        step();
        step();
        arb_rst_n = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready == '0 && n < 400) begin
            step();
            n++;
        end
        check({tag, "_wait"}, 32'(req_ready != '0), 1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            step();
        end
    endtask

    task automatic serve_frame(input string tag, input int id, input logic [7:0] d,
                               input bit clear, input int delay);
        int n;
        wait_ready(tag);
        check({tag, "_ready"}, req_ready, 32'(1 << id));
        check({tag, "_gid"}, grant_id, id);
        check({tag, "_data"}, tx_data_out, d);
        check({tag, "_nostart"}, tx_start, 0);
        if (clear) req_valid[id] = 1'b0;
        step();
        check({tag, "_start"}, tx_start, 1);
        check({tag, "_hold"}, tx_data_out, d);
        repeat (delay) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        wait_idle(n);
        check({tag, "_gap"}, n, GAP_LEN);
    endtask

    // One cycle of randomized requesters, fake uart_tx and scoreboard.
    task automatic rnd_cycle(input bit allow_new);
        int w;
        int exp_b;
        v_edge = req_valid;
        step();
        tx_done = 1'b0;
        if (tx_start || start_exp) check("rnd_start", tx_start, start_exp);
        start_exp = 1'b0;
        if (tx_start) begin
            exp_b = (q.size() > 0) ? q.pop_front() : -1;
            check("rnd_byte", tx_data_out, exp_b);
            starts++;
            done_timer = $urandom_range(40, 1);
        end else if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) begin
                tx_done    = 1'b1;
                done_edge  = cyc + 1;
                done_timer = -1;
            end
        end
        w = -1;
        if (req_ready != '0) begin
            w = rr_pick(v_edge, mptr);
            check("rnd_ready", req_ready, (w >= 0) ? 32'(1 << w) : 0);
            check("rnd_gap", 32'(cyc - done_edge >= GAP_LEN + 1), 1);
            if (w >= 0) begin
                check("rnd_gid", grant_id, w);
                check("rnd_data", tx_data_out, req_data[8*w +: 8]);
                q.push_back(int'(req_data[8*w +: 8]));
                mptr = (w + 1) % NR;
                if (allow_new && $urandom_range(1, 0) == 1) req_data[8*w +: 8] = 8'($urandom);
                else req_valid[w] = 1'b0;
            end
            start_exp = 1'b1;
            grants++;
        end
        for (int i = 0; i < NR; i++) begin
            if (i != w) begin
                if (!req_valid[i] && allow_new && $urandom_range(15, 0) == 0) begin
                    set_req(i, 8'($urandom));
                end else if (req_valid[i] && $urandom_range(199, 0) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        int n;

        // Reset state
        do_reset();
        check("reset_outs", {req_ready, tx_start, tx_data_out, grant_id, busy, timeout_err}, 0);

        // Single request
        set_req(0, 8'hAB);
        serve_frame("single", 0, 8'hAB, 1'b1, 5);
        check("single_idle_busy", busy, 0);

        // All four continuously valid: strict rotation
        do_reset();
        set_req(0, 8'h10);
        set_req(1, 8'h20);
        set_req(2, 8'h30);
        set_req(3, 8'h40);
        serve_frame("rr0", 0, 8'h10, 1'b0, 3);
        serve_frame("rr1", 1, 8'h20, 1'b0, 7);
        serve_frame("rr2", 2, 8'h30, 1'b0, 1);
        serve_frame("rr3", 3, 8'h40, 1'b0, 12);
        serve_frame("rr4", 0, 8'h10, 1'b0, 2);

        // Pointer fairness: after 2, search starts at 3 and wraps to 0
        do_reset();
        set_req(2, 8'h33);
        serve_frame("fair2", 2, 8'h33, 1'b1, 4);
        set_req(0, 8'h11);
        set_req(2, 8'h33);
        serve_frame("fair0", 0, 8'h11, 1'b1, 4);
        serve_frame("fair2b", 2, 8'h33, 1'b1, 4);

        // Watchdog timeout
        do_reset();
        set_req(0, 8'h5A);
        wait_ready("to");
        req_valid[0] = 1'b0;
        step();
        check("to_start", tx_start, 1);
        n = 0;
        while (!timeout_err && n < 1000) begin
            step();
            n++;
        end
        check("to_cycles", n, TO_LEN);
        check("to_busy", busy, 1);
        wait_idle(n);
        check("to_gap", n, GAP_LEN);
        set_req(1, 8'h77);
        serve_frame("to_next", 1, 8'h77, 1'b1, 5);
        check("to_sticky", timeout_err, 1);

        // tx_done on the watchdog threshold edge wins
        do_reset();
        set_req(3, 8'hE1);
        wait_ready("same");
        check("same_gid", grant_id, 3);
        req_valid[3] = 1'b0;
        step();
        check("same_start", tx_start, 1);
        repeat (TO_LEN - 1) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("same_terr", timeout_err, 0);
        check("same_busy", busy, 1);
        wait_idle(n);
        check("same_gap", n, GAP_LEN);
        check("same_terr_end", timeout_err, 0);

        // Reset in WAIT abandons the frame and restarts the pointer at 0
        do_reset();
        set_req(0, 8'h5A);
        set_req(1, 8'h6B);
        wait_ready("rstw");
        check("rstw_first", req_ready, 4'b0001);
        step();
        step();
        step();
        arb_rst_n = 1'b0;
        step();
        check("rstw_outs", {req_ready, tx_start, tx_data_out, grant_id, busy, timeout_err}, 0);
        arb_rst_n = 1'b1;
        step();
        check("rstw_regrant", req_ready, 4'b0001);
        check("rstw_gid", grant_id, 0);
        req_valid[0] = 1'b0;
        step();
        check("rstw_start", tx_start, 1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        wait_idle(n);
        serve_frame("rstw_next", 1, 8'h6B, 1'b1, 4);

        // Randomized requesters against the round-robin model
        do_reset();
        mptr       = 0;
        q          = {};
        done_timer = -1;
        done_edge  = -1000;
        start_exp  = 1'b0;
        grants     = 0;
        starts     = 0;
        for (int c = 0; c < 4000; c++) rnd_cycle(1'b1);
        n = 0;
        while (req_valid != '0 && n < 5000) begin
            rnd_cycle(1'b0);
            n++;
        end
        repeat (100) rnd_cycle(1'b0);
        check("rnd_drain", req_valid, 0);
        check("rnd_starts", starts, grants);
        check("rnd_some", 32'(grants > 10), 1);
        check("rnd_terr", timeout_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
